// File: rtl/im_boot_loader_if.sv
// Instruction stream handshake between a word source and the boot loader.
//   s_valid : source has a word on s_data
//   s_data  : 32-bit instruction word
//   s_ready : loader accepts the word this cycle
interface im_boot_loader_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/im_boot_loader.sv
// Instruction-memory boot loader.
// Streams i_len words into consecutive IM word addresses while holding the core in
// reset, then hands the IM address port to the fetch stage and releases the core.
// The IM port is shared: writes only happen in LOAD/FLUSH, fetch addresses only pass
// through in RUN.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_start/i_len : start pulse and word count (sampled in IDLE or RUN only)
//   s_bus         : instruction word stream (valid/ready)
//   i_fetch_addr  : fetch-stage byte address, forwarded in RUN
//   o_im_*        : IM address / byte write enables / write data
//   o_core_rst_n  : core reset, low except in RUN
//   o_busy        : LOAD or FLUSH
//   o_done        : one-cycle pulse on the first RUN cycle
//   o_err         : sticky, last start had an illegal length
//   o_csum        : XOR of all words accepted in the current load
module im_boot_loader #(
  parameter int unsigned IM_DEPTH = 1024,
  parameter int unsigned ADDR_W   = $clog2(IM_DEPTH) + 2,
  parameter int unsigned LEN_W    = $clog2(IM_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  im_boot_loader_if.slave   s_bus,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [3:0]        o_im_wen,
  output logic [31:0]       o_im_wdata,
  output logic              o_core_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_csum
);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StRun} state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   len_q;
  // LEN_W wide so a full IM_DEPTH load never wraps before the last-word compare.
  logic [LEN_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [3:0]         wen_q;
  logic [31:0]        wdata_q;
  logic [31:0]        csum_q;
  logic               core_rst_n_q;
  logic               done_q;
  logic               err_q;

  logic               len_ok;
  logic               hs;
  logic               last_word;

  assign len_ok    = (i_len != '0) && (i_len <= LEN_W'(IM_DEPTH));
  assign hs        = (state_q == StLoad) && s_bus.s_valid;
  assign last_word = (cnt_q == len_q - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      len_q        <= '0;
      cnt_q        <= '0;
      wr_addr_q    <= '0;
      wen_q        <= '0;
      wdata_q      <= '0;
      csum_q       <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wen_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        StIdle, StRun: begin
          if (i_start) begin
            if (len_ok) begin
              len_q        <= i_len;
              cnt_q        <= '0;
              csum_q       <= '0;
              err_q        <= 1'b0;
              core_rst_n_q <= 1'b0;
              state_q      <= StLoad;
            end else begin
              // Bad length: flag it, leave state and core untouched.
              err_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (hs) begin
            wen_q     <= 4'hF;
            wdata_q   <= s_bus.s_data;
            wr_addr_q <= {cnt_q[ADDR_W-3:0], 2'b00};
            cnt_q     <= cnt_q + 1'b1;
            csum_q    <= csum_q ^ s_bus.s_data;
            if (last_word) begin
              state_q <= StFlush;
            end
          end
        end
        StFlush: begin
          // The final write is on the bus this cycle; release the core next.
          state_q      <= StRun;
          core_rst_n_q <= 1'b1;
          done_q       <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_bus.s_ready = (state_q == StLoad);
  assign o_busy        = (state_q == StLoad) || (state_q == StFlush);

  always_comb begin
    o_im_addr = wr_addr_q;
    if (state_q == StRun) begin
      o_im_addr = i_fetch_addr;
    end else if (state_q == StIdle) begin
      o_im_addr = '0;
    end
  end

  assign o_im_wen     = wen_q;
  assign o_im_wdata   = wdata_q;
  assign o_core_rst_n = core_rst_n_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_csum       = csum_q;

endmodule

// File: tb/tb_im_boot_loader.sv
// Self-checking bench for im_boot_loader: table-driven start/fetch vectors plus a
// write scoreboard filled when stream words are driven and drained by the IM monitor.
module tb_im_boot_loader;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = $clog2(DEPTH) + 2;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic [LW-1:0] i_len;
  logic [AW-1:0] i_fetch_addr;
  logic [AW-1:0] o_im_addr;
  logic [3:0]    o_im_wen;
  logic [31:0]   o_im_wdata;
  logic          o_core_rst_n;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [31:0]   o_csum;

  im_boot_loader_if s_if ();

  im_boot_loader #(
    .IM_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_len       (i_len),
    .s_bus       (s_if.slave),
    .i_fetch_addr(i_fetch_addr),
    .o_im_addr   (o_im_addr),
    .o_im_wen    (o_im_wen),
    .o_im_wdata  (o_im_wdata),
    .o_core_rst_n(o_core_rst_n),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_csum      (o_csum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            due;
  } wr_t;

  typedef struct {
    logic [LW-1:0] len;
    logic          exp_err;
  } start_vec_t;

  typedef struct {
    logic [AW-1:0] fetch;
    logic [AW-1:0] exp_addr;
  } fetch_vec_t;

  wr_t   sb_q[$];
  wr_t   sb_e;
  int    exp_cnt;
  logic [31:0] exp_csum;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // IM write monitor: every write must match the oldest expected write, on its cycle.
  always @(negedge clk) begin
    if (rst_n && o_im_wen != 4'h0) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h, expected no write",
                 o_im_addr, o_im_wdata);
      end else begin
        sb_e = sb_q.pop_front();
        check("wr_addr", 32'(o_im_addr), 32'(sb_e.addr));
        check("wr_data", o_im_wdata, sb_e.data);
        check("wr_wen", 32'(o_im_wen), 32'hF);
        check("wr_cycle", cyc, sb_e.due);
        check("wr_busy", 32'(o_busy), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LW-1:0] len, input bit accept);
    i_start = 1'b1;
    i_len   = len;
    tick();
    i_start = 1'b0;
    if (accept) begin
      exp_cnt  = 0;
      exp_csum = '0;
    end
  endtask

  task automatic send_word(input logic [31:0] d);
    wr_t w;
    check("s_ready_load", 32'(s_if.s_ready), 32'd1);
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    w.addr = AW'(exp_cnt * 4);
    w.data = d;
    w.due  = cyc + 1;
    sb_q.push_back(w);
    exp_cnt++;
    exp_csum = exp_csum ^ d;
    tick();
    s_if.s_valid = 1'b0;
  endtask

  task automatic gap();
    s_if.s_valid = 1'b0;
    s_if.s_data  = 32'hDEAD_BEEF;
    check("s_ready_gap", 32'(s_if.s_ready), 32'd1);
    tick();
  endtask

  // Called in the cycle after the last handshake (FLUSH).
  task automatic finish_load();
    check("flush_ready", 32'(s_if.s_ready), 32'd0);
    check("flush_busy", 32'(o_busy), 32'd1);
    check("flush_core_rst", 32'(o_core_rst_n), 32'd0);
    check("flush_done", 32'(o_done), 32'd0);
    tick();
    check("run_done", 32'(o_done), 32'd1);
    check("run_core_rst", 32'(o_core_rst_n), 32'd1);
    check("run_busy", 32'(o_busy), 32'd0);
    check("run_ready", 32'(s_if.s_ready), 32'd0);
    check("run_wen", 32'(o_im_wen), 32'd0);
    check("run_csum", o_csum, exp_csum);
    check("sb_empty", sb_q.size(), 32'd0);
    tick();
    check("run_done_pulse", 32'(o_done), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(s_if.s_ready), 32'd0);
    check({tag, "_wen"}, 32'(o_im_wen), 32'd0);
    check({tag, "_wdata"}, o_im_wdata, 32'd0);
    check({tag, "_addr"}, 32'(o_im_addr), 32'd0);
    check({tag, "_core_rst"}, 32'(o_core_rst_n), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_csum"}, o_csum, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  start_vec_t stv[3];
  fetch_vec_t ftv[4];
  logic [31:0] prog[3];
  bit          pat[6];

  initial begin
    int k;
    stv[0] = '{len: LW'(0),           exp_err: 1'b1};
    stv[1] = '{len: LW'(DEPTH + 1),   exp_err: 1'b1};
    stv[2] = '{len: LW'(2 * DEPTH - 1), exp_err: 1'b1};
    ftv[0] = '{fetch: AW'(8'h10), exp_addr: AW'(8'h10)};
    ftv[1] = '{fetch: AW'(8'h14), exp_addr: AW'(8'h14)};
    ftv[2] = '{fetch: AW'(8'hFC), exp_addr: AW'(8'hFC)};
    ftv[3] = '{fetch: AW'(8'h00), exp_addr: AW'(8'h00)};
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_8113;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_len        = '0;
    i_fetch_addr = '0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    exp_cnt      = 0;
    exp_csum     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Illegal lengths in IDLE.
    for (int i = 0; i < 3; i++) begin
      do_start(stv[i].len, !stv[i].exp_err);
      check("bad_len_err", 32'(o_err), 32'(stv[i].exp_err));
      check("bad_len_busy", 32'(o_busy), 32'd0);
      check("bad_len_core", 32'(o_core_rst_n), 32'd0);
      check("bad_len_ready", 32'(s_if.s_ready), 32'd0);
      check("bad_len_addr", 32'(o_im_addr), 32'd0);
    end

    // Back-to-back load of three words; a valid start clears the error.
    do_start(LW'(3), 1'b1);
    check("start_err_clear", 32'(o_err), 32'd0);
    check("start_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 3; i++) send_word(prog[i]);
    finish_load();

    // Same program with a gappy stream, reloaded from RUN.
    do_start(LW'(3), 1'b1);
    check("reload_core_rst", 32'(o_core_rst_n), 32'd0);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (pat[i]) begin
        send_word(prog[k]);
        k++;
      end else begin
        gap();
      end
    end
    finish_load();

    // Fetch pass-through in RUN, same-cycle.
    for (int i = 0; i < 4; i++) begin
      i_fetch_addr = ftv[i].fetch;
      #1;
      check("fetch_addr", 32'(o_im_addr), 32'(ftv[i].exp_addr));
      check("fetch_wen", 32'(o_im_wen), 32'd0);
      tick();
    end

    // Illegal start in RUN leaves the core running.
    i_fetch_addr = AW'(8'h24);
    do_start(LW'(0), 1'b0);
    check("run_bad_err", 32'(o_err), 32'd1);
    check("run_bad_core", 32'(o_core_rst_n), 32'd1);
    check("run_bad_busy", 32'(o_busy), 32'd0);
    check("run_bad_addr", 32'(o_im_addr), 32'h24);

    // Single-word reload from RUN.
    do_start(LW'(1), 1'b1);
    check("reload1_core_rst", 32'(o_core_rst_n), 32'd0);
    check("reload1_err", 32'(o_err), 32'd0);
    send_word(32'hCAFE_F00D);
    finish_load();

    // Full memory load.
    do_start(LW'(DEPTH), 1'b1);
    for (int i = 0; i < int'(DEPTH); i++) send_word($urandom);
    finish_load();
    repeat (3) tick();

    // Starts during LOAD are ignored: counter and length keep going.
    do_start(LW'(4), 1'b1);
    send_word(32'h1111_0001);
    send_word(32'h2222_0002);
    i_start = 1'b1;
    i_len   = LW'(2);
    tick();
    check("ign_start_err", 32'(o_err), 32'd0);
    i_len = LW'(0);
    tick();
    i_start = 1'b0;
    check("ign_bad_err", 32'(o_err), 32'd0);
    check("ign_busy", 32'(o_busy), 32'd1);
    send_word(32'h3333_0003);
    send_word(32'h4444_0004);
    finish_load();

    // Asynchronous reset in the middle of a load.
    do_start(LW'(5), 1'b1);
    send_word(32'hAAAA_0001);
    send_word(32'hBBBB_0002);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(o_busy), 32'd0);
    check("post_rst_core", 32'(o_core_rst_n), 32'd0);
    do_start(LW'(1), 1'b1);
    send_word(32'h0BAD_CAFE);
    finish_load();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
